radio_timing_engine_mc: RTL
===========================

Name: radio_timing_engine_mc

Overview:
- Multi-channel, parametrised successor to the two-stage timing-engine path.
- Sits in the always-on side (PD_M2-class domain) and receives per-channel pllSettled/tArstFs from a less-on source domain.
- Runs per-channel enable/RX-enable sequencing with programmable delays.
- Handles source-domain isolation explicitly: clamps inputs, aborts sequences, and applies a guard period after isolation release.

Parameters:
- NUM_CH, 2, number of independent radio timing channels.
- CNT_W, 8, width of delay counters and delay inputs.
- SYNC_STAGES, 2, synchroniser depth for source-domain inputs (legal range 2..4).
- GUARD_CYC, 4, cycles after isolateSrc falls during which source inputs are ignored.

Ports:
- ck  in  1  clock.
- arst  in  1  asynchronous active-low reset.
- isolateSrc  in  1  source-domain isolation enable; high = source inputs invalid.
- pllSettled  in  NUM_CH  per-channel PLL settled, from source domain.
- tArstFs  in  NUM_CH  per-channel sequence request, level; low aborts.
- rxMode  in  NUM_CH  per-channel: 1 = also sequence radioRxEn.
- enDelay  in  CNT_W  cycles from PLL settled to radioEnable; shared by all channels.
- rxDelay  in  CNT_W  cycles from radioEnable to radioRxEn; shared.
- radioEnable  out  NUM_CH  per-channel radio enable.
- radioRxEn  out  NUM_CH  per-channel RX enable.
- busy  out  1  OR of all channels not in IDLE.

Behaviour:
- Reset (arst low): all state goes to IDLE, counters 0, synchronisers 0, guard counter 0; radioEnable=0, radioRxEn=0, busy=0, all asynchronously.
- Input conditioning: pllSettled and tArstFs are each passed through a SYNC_STAGES flop chain.
  - Effective input = synchronised value AND NOT srcBlocked.
  - srcBlocked = isolateSrc OR (guard counter != 0).
  - isolateSrc is itself already in the ck domain and is not synchronised.
- Guard: on isolateSrc falling (registered edge), the guard counter loads GUARD_CYC and decrements to 0 each cycle. isolateSrc rising again reloads it on its next fall.
- Per-channel FSM (states: IDLE, WAIT_PLL, EN_DLY, ACTIVE, RX_DLY, RX_ON):
  - IDLE -> WAIT_PLL when effective tArstFs=1.
  - WAIT_PLL -> EN_DLY when effective pllSettled=1; counter loads enDelay.
  - EN_DLY: counter decrements; when counter==0 go to ACTIVE. enDelay=0 gives ACTIVE on the next cycle.
  - ACTIVE: radioEnable=1. If rxMode=1, go to RX_DLY with counter loaded from rxDelay; otherwise stay.
  - RX_DLY: decrement; at 0 go to RX_ON.
  - RX_ON: radioEnable=1 and radioRxEn=1.
  - Any non-IDLE state -> IDLE when effective tArstFs=0. This has priority over all other transitions.
  - In EN_DLY, ACTIVE, RX_DLY or RX_ON, effective pllSettled=0 -> WAIT_PLL, with outputs dropped.
  - rxMode falling in RX_DLY or RX_ON -> ACTIVE.
- Outputs are registered: decoded from the next state, so they are valid in the same cycle the FSM state becomes valid.
- Latency: tArstFs and pllSettled both high before the synchronisers gives radioEnable high SYNC_STAGES+2+enDelay cycles after the later input edge.
- Delay inputs are sampled only at counter load; changes mid-count have no effect.
- Isolation mid-sequence: isolateSrc high forces effective inputs to 0, so every channel returns to IDLE one cycle later and outputs fall.
  - Outputs never glitch high during isolation.
  - After release, a new sequence cannot start before GUARD_CYC cycles elapse.
- Channels are fully independent apart from the shared delays and the guard.

Decomposition:
- Package radio_timing_pkg:
  - rte_state_e enum (IDLE..RX_ON, 3 bits).
  - RTE_SYNC_MIN=2, RTE_SYNC_MAX=4.
  - Elaboration-time assertion limits on SYNC_STAGES.
- Sub-module rte_channel: one FSM, counter and output register per channel, generated NUM_CH times.
- The top holds the synchronisers, the guard counter and the busy OR.

Test Plan:
- Reset and basic sequence: release arst; ch0 tArstFs=1, pllSettled=1, rxMode=0, enDelay=3 -> radioEnable[0] rises 7 cycles later (SYNC_STAGES=2); radioRxEn stays 0; busy=1 from cycle 3.
- RX sequencing: ch1 rxMode=1, enDelay=0, rxDelay=5 -> radioEnable[1] rises 4 cycles after inputs; radioRxEn[1] rises exactly 6 cycles after radioEnable[1].
- Abort priority: in RX_ON, drop tArstFs and pllSettled in the same cycle -> both outputs 0 SYNC_STAGES+1 cycles later; state IDLE, not WAIT_PLL.
- Isolation mid-sequence: assert isolateSrc during EN_DLY with inputs held high -> outputs stay 0 and the channel goes to IDLE next cycle.
  - Release isolateSrc -> no WAIT_PLL entry for 4 cycles (GUARD_CYC); radioEnable then rises after the normal enDelay path.
- Async reset mid-operation: arst low while both channels are in RX_ON -> all outputs 0 immediately (no clock edge); after release the FSM restarts from IDLE and pays the full synchroniser latency.
- Boundaries: enDelay=255 -> radioEnable after 255+4 cycles with no counter wrap; change enDelay mid-count -> timing unchanged; NUM_CH=4 build with staggered requests -> channels independent.

Source files
------------

// File: rtl/radio_timing_pkg.sv
// Shared types and limits for the multi-channel radio timing engine.
package radio_timing_pkg;

  localparam int unsigned RTE_SYNC_MIN = 2;
  localparam int unsigned RTE_SYNC_MAX = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPll,
    StEnDly,
    StActive,
    StRxDly,
    StRxOn
  } rte_state_e;

endpackage

// File: rtl/radio_timing_engine_mc_if.sv
// Control/status bundle between the source-side controller and the timing engine.
interface radio_timing_engine_mc_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8
);
  logic              isolateSrc;
  logic [NUM_CH-1:0] pllSettled;
  logic [NUM_CH-1:0] tArstFs;
  logic [NUM_CH-1:0] rxMode;
  logic [CNT_W-1:0]  enDelay;
  logic [CNT_W-1:0]  rxDelay;
  logic [NUM_CH-1:0] radioEnable;
  logic [NUM_CH-1:0] radioRxEn;
  logic              busy;

  modport master (
    output isolateSrc, pllSettled, tArstFs, rxMode, enDelay, rxDelay,
    input  radioEnable, radioRxEn, busy
  );

  modport slave (
    input  isolateSrc, pllSettled, tArstFs, rxMode, enDelay, rxDelay,
    output radioEnable, radioRxEn, busy
  );
endinterface

// File: rtl/rte_channel.sv
// One radio timing channel: sequencing FSM, shared-width delay counter and
// output registers decoded from the next state.
module rte_channel
  import radio_timing_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             req,
  input  logic             pll,
  input  logic             rx_mode,
  input  logic [CNT_W-1:0] en_delay,
  input  logic [CNT_W-1:0] rx_delay,
  output logic             radio_enable,
  output logic             radio_rx_en,
  output logic             busy
);

  rte_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A zero delay bypasses the delay state; otherwise the state exits when
  // the loaded count reaches 1, giving exactly 'delay' cycles in it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!req) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      state_d = StWaitPll;
    end else if (!pll) begin
      state_d = StWaitPll;
    end else begin
      case (state_q)
        StWaitPll: begin
          if (en_delay == '0) begin
            state_d = StActive;
          end else begin
            state_d = StEnDly;
            cnt_d   = en_delay;
          end
        end
        StEnDly: begin
          if (cnt_q <= CNT_W'(1)) state_d = StActive;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        StActive: begin
          if (rx_mode) begin
            if (rx_delay == '0) begin
              state_d = StRxOn;
            end else begin
              state_d = StRxDly;
              cnt_d   = rx_delay;
            end
          end
        end
        StRxDly: begin
          if (!rx_mode)                state_d = StActive;
          else if (cnt_q <= CNT_W'(1)) state_d = StRxOn;
          else                         cnt_d   = cnt_q - CNT_W'(1);
        end
        StRxOn: begin
          if (!rx_mode) state_d = StActive;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      radio_enable <= 1'b0;
      radio_rx_en  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      radio_enable <= state_d inside {StActive, StRxDly, StRxOn};
      radio_rx_en  <= (state_d == StRxOn);
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: rtl/radio_timing_engine_mc.sv
// Multi-channel radio timing engine: source-domain synchronisers, isolation
// clamp with post-release guard, and NUM_CH independent sequencing channels.
module radio_timing_engine_mc
  import radio_timing_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GUARD_CYC   = 4
) (
  input logic                    ck,
  input logic                    arst,
  radio_timing_engine_mc_if.slave bus
);

  if (SYNC_STAGES < RTE_SYNC_MIN || SYNC_STAGES > RTE_SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES must be within 2..4");
  end

  localparam int unsigned GuardW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] pll_sync_q, req_sync_q;
  logic [GuardW-1:0]                  guard_q, guard_d;
  logic                               iso_q;
  logic                               src_blocked;
  logic [NUM_CH-1:0]                  pll_eff, req_eff;
  logic [NUM_CH-1:0]                  en_vec, rx_vec, ch_busy;

  always_comb begin
    guard_d = guard_q;
    if (iso_q && !bus.isolateSrc) guard_d = GuardW'(GUARD_CYC);
    else if (guard_q != '0)       guard_d = guard_q - GuardW'(1);
  end

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      pll_sync_q <= '0;
      req_sync_q <= '0;
      guard_q    <= '0;
      iso_q      <= 1'b0;
    end else begin
      pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], bus.pllSettled};
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.tArstFs};
      guard_q    <= guard_d;
      iso_q      <= bus.isolateSrc;
    end
  end

  // iso_q covers the release cycle itself, before the guard counter has loaded.
  assign src_blocked = bus.isolateSrc | iso_q | (guard_q != '0);
  assign pll_eff     = pll_sync_q[SYNC_STAGES-1] & {NUM_CH{~src_blocked}};
  assign req_eff     = req_sync_q[SYNC_STAGES-1] & {NUM_CH{~src_blocked}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rte_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .ck          (ck),
      .arst        (arst),
      .req         (req_eff[c]),
      .pll         (pll_eff[c]),
      .rx_mode     (bus.rxMode[c]),
      .en_delay    (bus.enDelay),
      .rx_delay    (bus.rxDelay),
      .radio_enable(en_vec[c]),
      .radio_rx_en (rx_vec[c]),
      .busy        (ch_busy[c])
    );
  end

  assign bus.radioEnable = en_vec;
  assign bus.radioRxEn   = rx_vec;
  assign bus.busy        = |ch_busy;

endmodule
